// File: rtl/danger_if.sv
// Game-control <-> obstacle-spawner bundle: control inputs plus packed slot buses
// for the renderer and collision logic.
interface danger_if #(
  parameter int unsigned NUM_SLOTS = 3,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned SPEED_W   = 3
);
  localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

  logic                       tick;
  logic                       run;
  logic                       clear;
  logic [SPEED_W-1:0]         speed;
  logic [6:0]                 rnd;
  logic [NUM_SLOTS*POS_W-1:0] danger_pos;
  logic [NUM_SLOTS*3-1:0]     danger_type;
  logic [NUM_SLOTS-1:0]       danger_en;
  logic                       spawn_pulse;
  logic [CNT_W-1:0]           active_cnt;

  modport master (
    output tick, run, clear, speed, rnd,
    input  danger_pos, danger_type, danger_en, spawn_pulse, active_cnt
  );

  modport slave (
    input  tick, run, clear, speed, rnd,
    output danger_pos, danger_type, danger_en, spawn_pulse, active_cnt
  );
endinterface

// File: rtl/danger_spawner.sv
// Obstacle slot manager: scrolls enabled slots left each game tick and spawns
// new obstacles after a minimum gap, backing off when the roll was NOTHING.
module danger_spawner #(
  parameter int unsigned NUM_SLOTS     = 3,
  parameter int unsigned POS_W         = 10,
  parameter int unsigned SPAWN_X       = 640,
  parameter int unsigned GAP_W         = 10,
  parameter int unsigned MIN_GAP       = 400,
  parameter int unsigned RETRY_BACKOFF = 150,
  parameter int unsigned SPEED_W       = 3
) (
  input logic     clk,
  input logic     rst,
  danger_if.slave bus
);

  localparam int unsigned TYPE_W = 3;
  localparam int unsigned CNT_W  = $clog2(NUM_SLOTS + 1);

  localparam logic [TYPE_W-1:0] T_LOW_BIRD     = 3'd0;
  localparam logic [TYPE_W-1:0] T_HIGH_BIRD    = 3'd1;
  localparam logic [TYPE_W-1:0] T_SMALL_CACTUS = 3'd2;
  localparam logic [TYPE_W-1:0] T_MANY_CACTUS  = 3'd3;
  localparam logic [TYPE_W-1:0] T_BIG_CACTUS   = 3'd4;
  localparam logic [TYPE_W-1:0] T_NOTHING      = 3'd5;

  localparam bit PARAM_OK = (NUM_SLOTS >= 1) &&
                            ((SPAWN_X + 77) < (1 << POS_W)) &&
                            (MIN_GAP < (1 << GAP_W)) &&
                            (RETRY_BACKOFF <= MIN_GAP) &&
                            (SPEED_W < POS_W);

  function automatic logic [TYPE_W-1:0] decode_rnd(input logic [6:0] r);
    if (r <= 7'd50)      return T_NOTHING;
    else if (r <= 7'd60) return T_BIG_CACTUS;
    else if (r <= 7'd70) return T_SMALL_CACTUS;
    else if (r <= 7'd80) return T_MANY_CACTUS;
    else if (r <= 7'd90) return T_LOW_BIRD;
    else                 return T_HIGH_BIRD;
  endfunction

  function automatic logic [POS_W-1:0] type_width(input logic [TYPE_W-1:0] t);
    case (t)
      T_BIG_CACTUS:            return POS_W'(27);
      T_SMALL_CACTUS:          return POS_W'(19);
      T_MANY_CACTUS:           return POS_W'(77);
      T_LOW_BIRD, T_HIGH_BIRD: return POS_W'(47);
      default:                 return POS_W'(0);
    endcase
  endfunction

  logic [POS_W-1:0]  pos_q  [NUM_SLOTS];
  logic [POS_W-1:0]  pos_d  [NUM_SLOTS];
  logic [TYPE_W-1:0] type_q [NUM_SLOTS];
  logic [TYPE_W-1:0] type_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] en_q, en_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TYPE_W-1:0] pend_q, pend_d;
  logic              pulse_q, pulse_d;
  logic              spawned;
  logic [POS_W-1:0]  speed_ext;

  assign speed_ext = POS_W'(bus.speed);

  // Next state: move and spawn both read pre-tick state, so a slot freed this
  // tick cannot be reused until the following one.
  always_comb begin
    pos_d   = pos_q;
    type_d  = type_q;
    en_d    = en_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    pulse_d = 1'b0;
    spawned = 1'b0;

    if (bus.clear) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        pos_d[i]  = '0;
        type_d[i] = T_NOTHING;
      end
      en_d   = '0;
      gap_d  = '0;
      pend_d = T_NOTHING;
    end else if (bus.run && bus.tick) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (en_q[i]) begin
          if (pos_q[i] <= speed_ext) begin
            pos_d[i]  = '0;
            type_d[i] = T_NOTHING;
            en_d[i]   = 1'b0;
          end else begin
            pos_d[i] = pos_q[i] - speed_ext;
          end
        end
      end

      if (&en_q) begin
        gap_d = '0;
      end else if (gap_q < GAP_W'(MIN_GAP)) begin
        gap_d = gap_q + GAP_W'(1);
      end else begin
        pend_d = decode_rnd(bus.rnd);
        if (pend_q != T_NOTHING) begin
          for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!en_q[i] && !spawned) begin
              spawned   = 1'b1;
              pos_d[i]  = POS_W'(SPAWN_X) + type_width(pend_q);
              type_d[i] = pend_q;
              en_d[i]   = 1'b1;
            end
          end
          gap_d   = '0;
          pulse_d = 1'b1;
        end else begin
          gap_d = GAP_W'(MIN_GAP - RETRY_BACKOFF);
        end
      end
    end
  end

  // State registers; with run low every register holds and only the pulse drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        pos_q[i]  <= '0;
        type_q[i] <= T_NOTHING;
      end
      en_q    <= '0;
      gap_q   <= '0;
      pend_q  <= T_NOTHING;
      pulse_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      type_q  <= type_d;
      en_q    <= en_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (PARAM_OK);
  end

  logic [NUM_SLOTS*POS_W-1:0]  pos_flat;
  logic [NUM_SLOTS*TYPE_W-1:0] type_flat;
  logic [CNT_W-1:0]            cnt;

  // Flatten slot arrays onto the buses and count live obstacles.
  always_comb begin
    pos_flat  = '0;
    type_flat = '0;
    cnt       = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      pos_flat[i*POS_W +: POS_W]    = pos_q[i];
      type_flat[i*TYPE_W +: TYPE_W] = type_q[i];
      cnt = cnt + CNT_W'(en_q[i]);
    end
  end

  assign bus.danger_pos  = pos_flat;
  assign bus.danger_type = type_flat;
  assign bus.danger_en   = en_q;
  assign bus.spawn_pulse = pulse_q;
  assign bus.active_cnt  = cnt;

endmodule

// File: tb/tb_danger_spawner.sv
// Bench for danger_spawner: directed scenarios plus randomized control traffic,
// all checked against a slot-level reference model of the game rules.
module tb_danger_spawner;

  localparam int NS      = 3;
  localparam int POS_W   = 10;
  localparam int SPAWN_X = 640;
  localparam int GAP_W   = 10;
  localparam int MIN_GAP = 4;
  localparam int BACKOFF = 2;
  localparam int SPEED_W = 3;
  localparam int CNT_W   = $clog2(NS + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  danger_if #(.NUM_SLOTS(NS), .POS_W(POS_W), .SPEED_W(SPEED_W)) bus ();

  danger_spawner #(
    .NUM_SLOTS(NS), .POS_W(POS_W), .SPAWN_X(SPAWN_X), .GAP_W(GAP_W),
    .MIN_GAP(MIN_GAP), .RETRY_BACKOFF(BACKOFF), .SPEED_W(SPEED_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: obstacles as plain integers.
  int m_pos [NS];
  int m_typ [NS];
  bit m_en  [NS];
  int m_gap;
  int m_pend;
  bit m_pulse;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int obstacle_width(input int t);
    case (t)
      4: return 27;
      2: return 19;
      3: return 77;
      0, 1: return 47;
      default: return 0;
    endcase
  endfunction

  function automatic int roll_type(input int r);
    if (r <= 50) return 5;
    if (r <= 60) return 4;
    if (r <= 70) return 2;
    if (r <= 80) return 3;
    if (r <= 90) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_pos[i] = 0; m_typ[i] = 5; m_en[i] = 0;
    end
    m_gap = 0; m_pend = 5; m_pulse = 0;
  endtask

  task automatic model_step(input bit tk, input bit rn, input bit clr, input int spd, input int r);
    bit pre_en [NS];
    int live;
    if (clr) begin
      model_reset();
      return;
    end
    m_pulse = 0;
    if (!(tk && rn)) return;
    live = 0;
    for (int i = 0; i < NS; i++) begin
      pre_en[i] = m_en[i];
      if (m_en[i]) live++;
    end
    for (int i = 0; i < NS; i++) begin
      if (pre_en[i]) begin
        if (m_pos[i] <= spd) begin
          m_pos[i] = 0; m_typ[i] = 5; m_en[i] = 0;
        end else begin
          m_pos[i] = m_pos[i] - spd;
        end
      end
    end
    if (live == NS) begin
      m_gap = 0;
    end else if (m_gap < MIN_GAP) begin
      m_gap++;
    end else begin
      if (m_pend != 5) begin
        for (int i = 0; i < NS; i++) begin
          if (!pre_en[i]) begin
            m_pos[i] = SPAWN_X + obstacle_width(m_pend);
            m_typ[i] = m_pend;
            m_en[i]  = 1;
            break;
          end
        end
        m_gap = 0;
        m_pulse = 1;
      end else begin
        m_gap = MIN_GAP - BACKOFF;
      end
      m_pend = roll_type(r);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NS*POS_W-1:0] e_pos;
    logic [NS*3-1:0]     e_typ;
    logic [NS-1:0]       e_en;
    logic [CNT_W-1:0]    e_cnt;
    e_cnt = '0;
    for (int i = 0; i < NS; i++) begin
      e_pos[i*POS_W +: POS_W] = POS_W'(m_pos[i]);
      e_typ[i*3 +: 3]         = 3'(m_typ[i]);
      e_en[i]                 = m_en[i];
      e_cnt                   = e_cnt + CNT_W'(m_en[i]);
    end
    check({tag, ".pos"},   64'(bus.danger_pos),  64'(e_pos));
    check({tag, ".type"},  64'(bus.danger_type), 64'(e_typ));
    check({tag, ".en"},    64'(bus.danger_en),   64'(e_en));
    check({tag, ".pulse"}, 64'(bus.spawn_pulse), 64'(m_pulse));
    check({tag, ".cnt"},   64'(bus.active_cnt),  64'(e_cnt));
  endtask

  // One clock: DUT and model both consume the inputs present at the edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_step(bus.tick, bus.run, bus.clear, int'(bus.speed), int'(bus.rnd));
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    check({tag, ".en0"}, 64'(bus.danger_en), 64'(0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    bus.tick = 1'b0; bus.run = 1'b0; bus.clear = 1'b0;
    bus.speed = '0; bus.rnd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Startup gap, NOTHING retry, then first BIG spawn.
    bus.run = 1'b1; bus.tick = 1'b1; bus.speed = 3'd1; bus.rnd = 7'd55;
    for (int t = 1; t <= 7; t++) cyc("warmup");
    check("pre_spawn_en", 64'(bus.danger_en), 64'(0));
    cyc("spawn");
    check("spawn_pos0", 64'(bus.danger_pos[POS_W-1:0]), 64'(667));
    check("spawn_type0", 64'(bus.danger_type[2:0]), 64'(4));
    check("spawn_en0", 64'(bus.danger_en[0]), 64'(1));
    check("spawn_pulse", 64'(bus.spawn_pulse), 64'(1));
    cyc("move");
    check("move_pos0", 64'(bus.danger_pos[POS_W-1:0]), 64'(666));
    check("pulse_drop", 64'(bus.spawn_pulse), 64'(0));

    // Scroll slot0 down to pos 2, then free it with speed 3.
    bus.speed = 3'd7;
    guard = 0;
    while (m_pos[0] > 9 && guard < 500) begin cyc("scroll7"); guard++; end
    check("scroll7_bound", 64'(guard < 500), 64'(1));
    bus.speed = 3'd1;
    guard = 0;
    while (m_pos[0] > 2 && guard < 50) begin cyc("scroll1"); guard++; end
    check("slot0_at_2", 64'(bus.danger_pos[POS_W-1:0]), 64'(2));
    bus.speed = 3'd3;
    cyc("expire");
    check("expire_en0", 64'(bus.danger_en[0]), 64'(0));
    check("expire_type0", 64'(bus.danger_type[2:0]), 64'(5));
    check("expire_pos0", 64'(bus.danger_pos[POS_W-1:0]), 64'(0));

    // Standing traffic fills every slot; a full row never spawns.
    bus.speed = 3'd0;
    guard = 0;
    while (!(m_en[0] && m_en[1] && m_en[2]) && guard < 100) begin cyc("fill"); guard++; end
    check("full_cnt", 64'(bus.active_cnt), 64'(3));
    for (int t = 0; t < 6; t++) cyc("full_hold");
    check("full_no_pulse", 64'(bus.spawn_pulse), 64'(0));

    // Freeze with run low, then clear coinciding with tick.
    bus.run = 1'b0;
    for (int t = 0; t < 10; t++) cyc("frozen");
    check("frozen_cnt", 64'(bus.active_cnt), 64'(3));
    bus.run = 1'b1; bus.clear = 1'b1; bus.speed = 3'd5;
    cyc("clear");
    check("clear_en", 64'(bus.danger_en), 64'(0));
    check("clear_pos", 64'(bus.danger_pos), 64'(0));
    bus.clear = 1'b0;

    async_reset("rst_mid");

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      bus.tick  = ($urandom % 4) != 0;
      bus.run   = ($urandom % 8) != 0;
      bus.clear = ($urandom % 300) == 0;
      bus.speed = SPEED_W'($urandom);
      bus.rnd   = 7'($urandom);
      cyc("rand");
      if (($urandom % 700) == 0) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/danger_spawner.md
Name: danger_spawner

Overview:
- Parametrised successor to the game's obstacle generator and scroller.
- Manages NUM_SLOTS obstacle slots. Each slot holds a position, a type and an enable. Slots scroll left by a programmable speed on each game tick.
- Spawns new obstacles from a random input, with a minimum-gap counter and a retry backoff.
- Sits between game-state control (run/clear) and the renderer/collision logic, which consume its packed buses.

Parameters:
- NUM_SLOTS, 3, number of obstacle slots (>=1).
- POS_W, 10, position width in pixels.
- SPAWN_X, 640, base spawn x (window width).
- GAP_W, 10, gap counter width.
- MIN_GAP, 400, ticks between spawn attempts (< 2^GAP_W).
- RETRY_BACKOFF, 150, gap decrement after a NOTHING attempt (<= MIN_GAP).
- SPEED_W, 3, speed input width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  game tick enable, one clk cycle wide.
- run  in  1  1 = game running (GAME_START); 0 = freeze all state.
- clear  in  1  synchronous clear (GAME_RESET).
- speed  in  SPEED_W  pixels moved per tick.
- rnd  in  7  random value, sampled on spawn attempts.
- danger_pos  out  NUM_SLOTS*POS_W  slot i at [i*POS_W +: POS_W].
- danger_type  out  NUM_SLOTS*3  slot i at [i*3 +: 3].
- danger_en  out  NUM_SLOTS  slot valid.
- spawn_pulse  out  1  one clk cycle high after a spawn.
- active_cnt  out  $clog2(NUM_SLOTS+1)  popcount of danger_en (combinational from registers).

Behaviour:
- Type codes: LOW_BIRD=0, HIGH_BIRD=1, SMALL_CACTUS=2, MANY_CACTUS=3, BIG_CACTUS=4, NOTHING=5.
- Widths: BIG=27, SMALL=19, MANY=77, birds=47, NOTHING=0.
- Decode of rnd (unsigned):
  - <=50 NOTHING
  - <=60 BIG
  - <=70 SMALL
  - <=80 MANY
  - <=90 LOW_BIRD
  - else HIGH_BIRD
- Reset (rst=0, async): all pos=0, all type=5, en=0, gap=0, pending type=NOTHING, spawn_pulse=0.
- clear=1 (rising clk edge): same values as reset. Takes priority over tick and run.
- run=0 and clear=0: every register holds, including gap and pending. spawn_pulse=0.
- On tick=1 with run=1 and clear=0, steps A and B are evaluated in parallel from pre-tick state.
- A. Move, per enabled slot:
  - if pos <= speed: en=0, type=5, pos=0.
  - else: pos = pos - speed.
  - Disabled slots are unchanged. speed=0 means no movement.
- B. Gap/spawn:
  - If all pre-tick en=1: gap=0.
  - Else if gap < MIN_GAP: gap = gap + 1.
  - Else (gap == MIN_GAP), if pending != NOTHING:
    - lowest-index slot with pre-tick en=0 gets pos = SPAWN_X + width(pending), type = pending, en = 1.
    - gap = 0; spawn_pulse = 1 next cycle.
  - Else (gap == MIN_GAP, pending == NOTHING): gap = MIN_GAP - RETRY_BACKOFF.
  - In both gap == MIN_GAP cases: pending = decode(rnd).
- Freed-slot timing: a slot freed by step A is not spawn-eligible until the next tick.
- Spawned slot: does not move on its spawn tick.
- tick=0: no state change except spawn_pulse returning to 0.
- Arithmetic: no wrap. Positions never underflow (saturating free). SPAWN_X + 77 < 2^POS_W is a parameter constraint, checked by a simulation assertion.

Test Plan:
1. Bench parameters: NUM_SLOTS=3, MIN_GAP=4, RETRY_BACKOFF=2, speed=1, rnd=55, run=1, tick every cycle.
   - rst low mid-run -> immediately pos=0, type=5, en=0, gap=0, spawn_pulse=0.
2. Same setup from reset:
   - Ticks 1-4 -> gap 1..4.
   - Tick 5 -> gap=2, pending=BIG.
   - Ticks 6-7 -> gap 3, 4.
   - Tick 8 -> slot0 pos=667, type=4, en=1; spawn_pulse high 1 cycle.
   - Tick 9 -> pos=666.
3. Slot0 pos=2, speed=3, tick -> slot0 en=0, type=5, pos=0; active_cnt decrements.
4. All 3 slots enabled, gap=3, tick -> gap=0, no spawn.
   - Next, slot1 expires -> the following spawn goes to slot1, not slot2.
5. run=0 for 10 ticks -> all outputs and gap frozen.
   - clear=1 asserted together with tick -> reset values, no move or spawn.
6. speed=0 with active slots -> positions constant; gap still advances.
